// File: rtl/link_pkg.sv
// Shared constants and types for the off-chip link transmit side.
// Ports: none (package).
//   Geometry of the downstream receiver buffer and of the core word,
//   the transmit FSM state type, and the credit derivation.
package link_pkg;

  localparam int LINK_BYTE_W    = 8;
  localparam int CORE_WORD_W    = 32;
  localparam int BEATS_PER_WORD = 4;
  localparam int RX_BUF_ENTRIES = 8;
  localparam int RX_ENTRY_W     = 16;
  localparam int TOKEN_ENTRIES  = 4;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_e;

  // Receiver capacity expressed in whole core words.
  function automatic int derive_credits();
    return RX_BUF_ENTRIES * RX_ENTRY_W / CORE_WORD_W;
  endfunction

  // Core words freed by one token toggle.
  function automatic int derive_token_words();
    return TOKEN_ENTRIES * RX_ENTRY_W / CORE_WORD_W;
  endfunction

endpackage

// File: rtl/link_token_sync.sv
// Credit-return token synchronizer.
// Ports:
//   clk         in  link clock
//   rst         in  synchronous active-high reset
//   token_in    in  asynchronous toggle from the receiver
//   token_event out one-cycle pulse per edge (rise or fall) of the synced token
module link_token_sync (
  input  logic clk,
  input  logic rst,
  input  logic token_in,
  output logic token_event
);

  logic sync1;
  logic sync2;
  logic last;

  // Flops reset to 0 because the receiver's token line also resets to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      last  <= 1'b0;
    end else begin
      sync1 <= token_in;
      sync2 <= sync1;
      last  <= sync2;
    end
  end

  assign token_event = sync2 ^ last;

endmodule

// File: rtl/link_tx_sched.sv
// Upstream link transmit scheduler.
// Round-robin arbitration of NUM_REQ core requesters, serialization of each
// granted 32-bit word into 4 bytes (low byte first), and credit flow control
// against the receiver buffer with credits returned as token toggles.
// Ports:
//   clk, rst      link clock, synchronous active-high reset
//   req_valid     per-requester word valid
//   req_data      packed words, requester i at [32i+31:32i]
//   req_ready     one-hot accept pulse (word taken this cycle)
//   io_valid_out  byte valid toward receiver
//   io_data_out   byte toward receiver (holds while not valid)
//   io_token_in   asynchronous credit toggle from receiver
//   credit_cnt    credits currently available
//   busy          high while serializing
//   grant_id      requester currently being sent
import link_pkg::*;

module link_tx_sched #(
  parameter int NUM_REQ     = 4,
  parameter int CREDITS     = derive_credits(),
  parameter int TOKEN_WORDS = derive_token_words(),
  parameter int CNT_W       = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*32-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       io_valid_out,
  output logic [7:0]                 io_data_out,
  input  logic                       io_token_in,
  output logic [CNT_W-1:0]           credit_cnt,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(BEATS_PER_WORD);
  localparam int SUM_W  = CNT_W + 2;
  localparam int unsigned NREQ_U = NUM_REQ;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_WORD - 1);

  tx_state_e              state;
  tx_state_e              state_nxt;
  logic [BEAT_W-1:0]      beat;
  logic [CORE_WORD_W-1:0] word;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        sel;
  logic                   grant;
  logic                   token_event;
  logic [SUM_W-1:0]       credit_sum;
  logic                   sat;
  logic [CNT_W-1:0]       credit_nxt;
  logic                   sat_err;

  link_token_sync u_token_sync (
    .clk         (clk),
    .rst         (rst),
    .token_in    (io_token_in),
    .token_event (token_event)
  );

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    grant = 1'b0;
    sel   = '0;
    idx   = 0;
    if (state == IDLE && credit_cnt != '0) begin
      for (int unsigned k = 0; k < NREQ_U; k++) begin
        idx = 32'(rr_ptr) + k;
        if (idx >= NREQ_U) idx = idx - NREQ_U;
        if (!grant && req_valid[idx[ID_W-1:0]]) begin
          grant = 1'b1;
          sel   = idx[ID_W-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[sel] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = SEND;
      SEND:    if (beat == LAST_BEAT) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A grant needs credit_cnt > 0 from the pick above, so the subtraction
  // cannot underflow even when a return lands in the same cycle.
  always_comb begin
    credit_sum = SUM_W'(credit_cnt) - SUM_W'(grant)
               + (token_event ? SUM_W'(TOKEN_WORDS) : '0);
    sat        = credit_sum > SUM_W'(CREDITS);
    credit_nxt = sat ? CNT_W'(CREDITS) : credit_sum[CNT_W-1:0];
  end

  // beat parks on the last beat after a word so io_data_out keeps showing
  // the final byte until the next grant reloads word and beat together.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat       <= '0;
      word       <= '0;
      rr_ptr     <= '0;
      grant_id   <= '0;
      credit_cnt <= CNT_W'(CREDITS);
      sat_err    <= 1'b0;
    end else begin
      if (grant) begin
        word     <= req_data[sel*CORE_WORD_W +: CORE_WORD_W];
        beat     <= '0;
        grant_id <= sel;
        rr_ptr   <= (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
      end else if (state == SEND && beat != LAST_BEAT) begin
        beat <= beat + 1'b1;
      end
      credit_cnt <= credit_nxt;
      if (sat) sat_err <= 1'b1;
    end
  end

  assign io_valid_out = (state == SEND);
  assign busy         = (state == SEND);
  assign io_data_out  = word[beat*LINK_BYTE_W +: LINK_BYTE_W];

  credit_bound: assert property (@(posedge clk) disable iff (rst)
    credit_cnt <= CNT_W'(CREDITS));
  ready_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready));
  credit_overflow_seen: cover property (@(posedge clk) sat_err);

endmodule

// File: tb/tb_link_tx_sched.sv
// Self-checking bench for link_tx_sched: directed scenarios followed by
// random traffic, all checked against a transaction-level model (expected
// byte queue, credit ledger with scheduled token returns, RR pointer).
module tb_link_tx_sched;

  localparam int NUM_REQ = 4;
  localparam int CREDITS = 4;
  localparam int TW      = 2;
  localparam int CNT_W   = 3;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  io_valid_out;
  logic [7:0]            io_data_out;
  logic                  io_token_in;
  logic [CNT_W-1:0]      credit_cnt;
  logic                  busy;
  logic [1:0]            grant_id;

  link_tx_sched #(
    .NUM_REQ     (NUM_REQ),
    .CREDITS     (CREDITS),
    .TOKEN_WORDS (TW),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .io_valid_out (io_valid_out),
    .io_data_out  (io_data_out),
    .io_token_in  (io_token_in),
    .credit_cnt   (credit_cnt),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  // reference model
  int          cyc;
  logic [7:0]  byteq[$];
  int          m_credit;
  int          m_ptr;
  int          m_gid;
  logic [7:0]  m_last;
  int          pend[int];
  logic [31:0] held[NUM_REQ];
  logic [31:0] nxt_data[NUM_REQ];
  logic [NUM_REQ-1:0] consumed;
  logic [NUM_REQ-1:0] want;
  logic        tog;
  int          grant_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = CREDITS;
    m_ptr    = 0;
    m_gid    = 0;
    m_last   = 8'h00;
    byteq.delete();
    pend.delete();
    consumed = '0;
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic window();
    logic idle;
    int sel;
    int ev;
    logic [31:0] w;
    logic [NUM_REQ-1:0] exp_rdy;
    idle = (byteq.size() == 0);
    if (!idle) m_last = byteq.pop_front();
    chk("io_valid", 32'(io_valid_out), 32'(!idle));
    chk("busy", 32'(busy), 32'(!idle));
    chk("io_data", 32'(io_data_out), 32'(m_last));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("credit", 32'(credit_cnt), 32'(m_credit));

    for (int i = 0; i < NUM_REQ; i++) begin
      if (consumed[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && want[i]) begin
        req_valid[i] = 1'b1;
        held[i] = nxt_data[i];
        req_data[32*i +: 32] = held[i];
        nxt_data[i] = $urandom;
      end
    end
    consumed = '0;
    if (tog) begin
      io_token_in = ~io_token_in;
      pend[cyc+3] = (pend.exists(cyc+3) ? pend[cyc+3] : 0) + TW;
    end
    #1;

    sel = -1;
    if (idle && m_credit > 0)
      for (int k = 0; k < NUM_REQ; k++) begin
        int j;
        j = (m_ptr + k) % NUM_REQ;
        if (sel < 0 && req_valid[j]) sel = j;
      end
    exp_rdy = (sel >= 0) ? NUM_REQ'(1 << sel) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) grant_log.push_back(k);

    ev = pend.exists(cyc+1) ? pend[cyc+1] : 0;
    if (pend.exists(cyc+1)) pend.delete(cyc+1);
    m_credit = m_credit - ((sel >= 0) ? 1 : 0) + ev;
    if (m_credit > CREDITS) m_credit = CREDITS;
    if (sel >= 0) begin
      w = held[sel];
      for (int b = 0; b < 4; b++) byteq.push_back(w[8*b +: 8]);
      m_gid = sel;
      m_ptr = (sel + 1) % NUM_REQ;
      consumed[sel] = 1'b1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    io_token_in = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int done;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    io_token_in = 1'b0;
    want = '0;
    tog = 1'b0;
    cyc = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      held[i] = '0;
      nxt_data[i] = $urandom;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // single word from requester 0
    nxt_data[0] = 32'hDEADBEEF;
    want = 4'b0001;
    window();
    want = '0;
    repeat (6) window();
    chk("single_grant0", 32'(grant_log.size() == 1 ? grant_log[0] : 99), 0);
    chk("single_credit", 32'(credit_cnt), 3);

    // credit exhaustion on requester 1
    do_reset();
    grant_log.delete();
    want = 4'b0010;
    repeat (30) window();
    chk("exhaust_words", grant_log.size(), 4);
    chk("exhaust_credit", 32'(credit_cnt), 0);
    chk("exhaust_ready", 32'(req_ready), 0);
    tog = 1'b1;
    window();
    tog = 1'b0;
    repeat (2) window();
    chk("token_latency", 32'(credit_cnt), 2);
    repeat (15) window();
    chk("refill_words", grant_log.size(), 6);

    // grant and token return on the same edge at credit 1
    tog = 1'b1;
    window();
    tog = 1'b0;
    done = 0;
    for (int n = 0; n < 40 && done == 0; n++) begin
      if (m_credit == 1 && byteq.size() == 2) begin
        tog = 1'b1;
        window();
        tog = 1'b0;
        repeat (2) window();
        chk("simul_credit", 32'(credit_cnt), 2);
        done = 1;
      end else begin
        window();
      end
    end
    chk("simul_reached", done, 1);

    // saturation
    do_reset();
    want = '0;
    tog = 1'b1;
    window();
    tog = 1'b0;
    repeat (5) window();
    chk("saturate", 32'(credit_cnt), 4);

    // round robin with ample tokens
    do_reset();
    grant_log.delete();
    want = 4'b1111;
    for (int n = 0; n < 30; n++) begin
      tog = (n % 3 == 0);
      window();
    end
    tog = 1'b0;
    for (int k = 0; k < 5; k++)
      chk("rr_order", 32'(grant_log.size() > k ? grant_log[k] : 99), k % NUM_REQ);

    // reset while sending beat 1
    done = 0;
    for (int n = 0; n < 20 && done == 0; n++) begin
      if (byteq.size() == 3) done = 1;
      else window();
    end
    chk("midsend_reached", done, 1);
    window();
    do_reset();
    chk("rst_valid", 32'(io_valid_out), 0);
    chk("rst_credit", 32'(credit_cnt), 4);
    chk("rst_gid", 32'(grant_id), 0);
    grant_log.delete();
    repeat (3) window();
    chk("rst_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : 99), 0);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      want = NUM_REQ'($urandom_range(0, 15));
      tog  = ($urandom_range(0, 5) == 0);
      window();
    end
    tog = 1'b0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/link_tx_sched.md
Name: link_tx_sched

Overview:
- Upstream-side scheduler for the off-chip link; it feeds the downstream channel receiver (8-entry x 16-bit buffer, 32-bit core words assembled from byte pairs).
- Arbitrates N core requesters round-robin and serializes each granted 32-bit word into 4 io bytes.
- Enforces credit flow control: never sends more words than the receiver buffer holds. Credits return as toggles on the receiver's token line.

Parameters:
- NUM_REQ, 4, number of core requesters (2..8).
- CREDITS, 4, receiver capacity in 32-bit words (8 entries x 16 bit).
- TOKEN_WORDS, 2, words freed per token toggle (receiver toggles once per 4 entries read).
- CNT_W, 3, credit counter width; must hold CREDITS.

Ports:
- clk  in  1  link clock.
- rst  in  1  reset; synchronous, active-high; clock clk.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*32  packed words; requester i at bits [32i+31:32i].
- req_ready  out  NUM_REQ  one-hot accept pulse; word taken that cycle.
- io_valid_out  out  1  byte valid toward receiver.
- io_data_out  out  8  byte toward receiver.
- io_token_in  in  1  asynchronous credit toggle from receiver.
- credit_cnt  out  CNT_W  current credits available.
- busy  out  1  high while serializing.
- grant_id  out  $clog2(NUM_REQ)  index of requester currently being sent.

Behaviour:
- Reset values: req_ready=0, io_valid_out=0, io_data_out=0, credit_cnt=CREDITS, busy=0, grant_id=0, RR pointer=0, FSM=IDLE, token sync flops=0, last token=0.
- The token sync flops reset to 0 because the receiver's token also resets to 0.
- Token path:
  - io_token_in passes through a 2-flop synchronizer.
  - Each edge (rise or fall) of the synced value is one return event.
  - Latency from input toggle to credit_cnt update is 3 clk.
- FSM states: IDLE and SEND.
- IDLE:
  - If any req_valid and credit_cnt>0, select the first valid requester at or after the RR pointer (wrapping).
  - Same cycle: assert req_ready[sel] for 1 cycle, capture the word, set grant_id=sel, decrement the credit.
  - Next cycle: enter SEND with beat=0. RR pointer <- sel+1 mod NUM_REQ.
  - If credit_cnt==0, grant nothing and leave req_ready all 0.
- SEND:
  - Four consecutive cycles, io_valid_out=1, bytes in order word[7:0], [15:8], [23:16], [31:24].
  - Low byte first, matching the receiver's {second,first} pairing and low-half-first core assembly.
  - After beat 3, return to IDLE; io_valid_out=0 for that IDLE cycle.
  - Minimum word period is therefore 5 cycles.
  - busy=1 throughout SEND.
  - io_data_out holds its last value when io_valid_out=0.
- Credit arithmetic:
  - next = cur - grant + (token_event ? TOKEN_WORDS : 0).
  - Simultaneous grant and return apply both in the same cycle.
  - Result saturates at CREDITS.
  - Saturation is also a sticky error flag internal to the assertion set, not a port.
  - A grant is never issued when cur==0, even if a return event occurs that cycle; the credit becomes usable the next cycle.
- Requester contract: req_data must be stable while req_valid is high; the word is consumed only on its req_ready pulse.
- Reset mid-SEND: the word is abandoned, io_valid_out drops the next cycle, credits restore to CREDITS.
- Link-level reset is coordinated so the receiver resets at the same time.

Decomposition:
- Shared package link_pkg:
  - LINK_BYTE_W=8, CORE_WORD_W=32, BEATS_PER_WORD=4, RX_BUF_ENTRIES=8, TOKEN_ENTRIES=4.
  - FSM enum {IDLE, SEND}.
  - Function deriving CREDITS = RX_BUF_ENTRIES*16/CORE_WORD_W.
- One sub-module link_token_sync: 2-flop synchronizer plus edge detector; outputs a 1-cycle token_event pulse.
- The round-robin pick stays inline.

Test Plan:
- Single word: requester 0 sends 0xDEADBEEF. Expect req_ready[0] for 1 cycle, bytes EF,BE,AD,DE on 4 consecutive cycles, credit_cnt 4->3.
- Credit exhaustion: requester 1 continuously valid, no token toggles. Expect exactly 4 words sent, then req_ready held 0 and credit_cnt=0.
- Toggle io_token_in once. Expect credit_cnt=2 three cycles later and 2 more words sent.
- Round-robin: all 4 requesters valid with ample tokens. Expect grant order 0,1,2,3,0, and grant_id matches each SEND.
- Simultaneous event: credit_cnt=1, a grant and a token event land in the same cycle. Expect credit_cnt=1+2-1=2.
- Saturation: a token toggle at credit_cnt=4 leaves credit_cnt=4.
- Reset mid-SEND: assert rst after beat 1. Expect io_valid_out=0 the following cycle, credit_cnt=4, grant_id=0, and a new grant restarting at requester 0 after reset.
